cbus_mem_responder: RTL and testbench

Synchronous cbus responder (slave) backed by an internal 64-bit-word SRAM. It answers page-table-walk reads and data/instruction accesses issued by cbus initiators such as the MMU, cache, or core. It serves as the memory end of simulation and FPGA test harnesses. It supports single and burst transfers with byte strobes and a programmable first-beat latency.

---
 rtl/cbus_mem_responder.sv | 159 +++++++++++++++
 tb/tb_cbus_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cbus_mem_responder.sv
// cbus slave backed by an internal 64-bit-word SRAM. It handles single and burst
// transfers with byte strobes and a fixed first-beat latency.
module cbus_mem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cbus_req_valid,
  input  logic        cbus_req_is_write,
  input  logic [2:0]  cbus_req_size,
  input  logic [63:0] cbus_req_addr,
  input  logic [7:0]  cbus_req_strobe,
  input  logic [63:0] cbus_req_data,
  input  logic [3:0]  cbus_req_len,
  input  logic [1:0]  cbus_req_burst,
  output logic        cbus_resp_ready,
  output logic        cbus_resp_last,
  output logic [63:0] cbus_resp_data,
  output logic        oob
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  len_q, len_d;
  logic        is_write_q, is_write_d;
  logic        fixed_q, fixed_d;
  logic [63:0] addr_q, addr_d;
  logic        ready_q, ready_d;
  logic        last_q, last_d;
  logic [63:0] data_q, data_d;
  logic        oob_q, oob_d;
  logic        beat_go;
  logic        wr_en;
  logic        size_unused;

  logic [63:0] mem_q [MEM_WORDS];

  // Transfer size never changes the 8-byte word step, so it is not decoded.
  assign size_unused = ^cbus_req_size;

  function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
    return AW'((a - BASE_ADDR) >> 3);
  endfunction

  function automatic logic out_of_range(input logic [63:0] a);
    return (a < BASE_ADDR) || ((a - BASE_ADDR) >= MEM_BYTES);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    len_d      = len_q;
    is_write_d = is_write_q;
    fixed_d    = fixed_q;
    addr_d     = addr_q;
    ready_d    = 1'b0;
    last_d     = 1'b0;
    data_d     = '0;
    oob_d      = 1'b0;
    beat_go    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cbus_req_valid) begin
          is_write_d = cbus_req_is_write;
          len_d      = cbus_req_len;
          fixed_d    = (cbus_req_burst == 2'b00);
          addr_d     = cbus_req_addr;
          beat_d     = '0;
          if (LATENCY == 1) begin
            state_d = BEAT;
            cnt_d   = '0;
            beat_go = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == '0) begin
          state_d = BEAT;
          beat_go = 1'b1;
        end
      end
      BEAT: begin
        if (beat_q == len_q) begin
          state_d = IDLE;
        end else begin
          beat_d  = beat_q + 4'd1;
          addr_d  = fixed_q ? addr_q : addr_q + 64'd8;
          beat_go = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so the beat about to start is resolved a cycle early.
    if (beat_go) begin
      ready_d = 1'b1;
      last_d  = (beat_d == len_d);
      oob_d   = out_of_range(addr_d);
      if (!is_write_d && !oob_d) data_d = mem_q[word_idx(addr_d)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      is_write_q <= 1'b0;
      fixed_q    <= 1'b0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      is_write_q <= is_write_d;
      fixed_q    <= fixed_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      last_q     <= last_d;
      data_q     <= data_d;
      oob_q      <= oob_d;
    end
  end

  // Write data is taken live in the beat cycle; reset in that cycle drops the beat.
  assign wr_en = (state_q == BEAT) && is_write_q && !oob_q && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (cbus_req_strobe[b]) mem_q[word_idx(addr_q)][8*b +: 8] <= cbus_req_data[8*b +: 8];
      end
    end
  end

  assign cbus_resp_ready = ready_q;
  assign cbus_resp_last  = last_q;
  assign cbus_resp_data  = data_q;
  assign oob             = oob_q;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: latency, bursts, strobes, back-to-back,
// out-of-range handling and reset during a write burst.
module tb_cbus_mem_responder;
  localparam int unsigned MEM_WORDS = 4096;
  localparam int unsigned LAT       = 2;
  localparam logic [63:0] BASE      = 64'h8000_0000;
  localparam logic [63:0] TOP       = BASE + 64'(MEM_WORDS) * 64'd8;
  localparam logic [1:0]  FIXED     = 2'b00;
  localparam logic [1:0]  INCR      = 2'b01;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_is_write;
  logic [2:0]  req_size;
  logic [63:0] req_addr;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic [3:0]  req_len;
  logic [1:0]  req_burst;
  logic        resp_ready;
  logic        resp_last;
  logic [63:0] resp_data;
  logic        oob;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] got_data [16];
  logic        got_last [16];
  logic        got_oob  [16];
  int          got_k    [16];
  int          got_n;

  cbus_mem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .BASE_ADDR(BASE),
    .LATENCY  (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cbus_req_valid   (req_valid),
    .cbus_req_is_write(req_is_write),
    .cbus_req_size    (req_size),
    .cbus_req_addr    (req_addr),
    .cbus_req_strobe  (req_strobe),
    .cbus_req_data    (req_data),
    .cbus_req_len     (req_len),
    .cbus_req_burst   (req_burst),
    .cbus_resp_ready  (resp_ready),
    .cbus_resp_last   (resp_last),
    .cbus_resp_data   (resp_data),
    .oob              (oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request (called just after a posedge) and records every beat.
  // k counts cycles after the acceptance edge; write data advances after each beat.
  task automatic xact(input string tag, input logic w, input logic [63:0] a,
                      input logic [3:0] l, input logic [1:0] b, input logic [7:0] s,
                      input logic [63:0] wd0, input logic hold, input logic [63:0] nxt,
                      input int rst_beat);
    int   nb;
    logic done;
    logic was_ready;
    logic was_last;
    req_valid    = 1'b1;
    req_is_write = w;
    req_size     = 3'd3;
    req_addr     = a;
    req_len      = l;
    req_burst    = b;
    req_strobe   = s;
    req_data     = wd0;
    nb   = 0;
    done = 1'b0;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= 64 && !done; k++) begin
      @(negedge clk);
      was_ready = resp_ready;
      was_last  = resp_ready && resp_last;
      if (resp_ready) begin
        if (nb < 16) begin
          got_data[nb] = resp_data;
          got_last[nb] = resp_last;
          got_oob[nb]  = oob;
          got_k[nb]    = k;
        end
        nb++;
        if (nb - 1 == rst_beat) rst = 1'b1;
      end
      @(posedge clk); #1;
      if (rst) begin
        rst  = 1'b0;
        done = 1'b1;
      end else begin
        if (was_ready) req_data = req_data + 64'd1;
        if (was_last) begin
          done = 1'b1;
          if (hold) req_addr = nxt;
        end
      end
    end
    got_n = nb;
    chk({tag, ".done"}, 64'(done), 64'd1);
  endtask

  task automatic chk_shape(input string tag, input int n);
    chk({tag, ".beats"}, 64'(got_n), 64'(n));
    for (int i = 0; i < n && i < 16; i++) begin
      chk($sformatf("%s.cycle%0d", tag, i), 64'(got_k[i]), 64'(LAT + i));
      chk($sformatf("%s.last%0d", tag, i), 64'(got_last[i]), 64'(i == n - 1));
    end
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_is_write = 1'b0;
    req_size     = '0;
    req_addr     = '0;
    req_strobe   = '0;
    req_data     = '0;
    req_len      = '0;
    req_burst    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ready", 64'(resp_ready), 64'd0);
    chk("reset.last", 64'(resp_last), 64'd0);
    chk("reset.data", resp_data, 64'd0);
    chk("reset.oob", 64'(oob), 64'd0);
    rst = 1'b0;

    xact("pre80", 1'b1, BASE + 64'h80, 4'd0, INCR, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b0, '0, -1);
    chk_shape("pre80", 1);
    chk("pre80.wdata", got_data[0], 64'd0);
    chk("pre80.oob", 64'(got_oob[0]), 64'd0);

    xact("rd80", 1'b0, BASE + 64'h80, 4'd0, INCR, 8'h00, '0, 1'b0, '0, -1);
    chk_shape("rd80", 1);
    chk("rd80.data", got_data[0], 64'hDEAD_BEEF_0123_4567);

    xact("pre08", 1'b1, BASE + 64'h8, 4'd0, INCR, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, -1);
    xact("strb08", 1'b1, BASE + 64'h8, 4'd0, INCR, 8'h0F, 64'h1111_2222_3333_4444, 1'b0, '0, -1);
    xact("rd08", 1'b0, BASE + 64'h8, 4'd0, INCR, 8'h00, '0, 1'b0, '0, -1);
    chk("rd08.data", got_data[0], 64'hFFFF_FFFF_3333_4444);

    xact("pre100", 1'b1, BASE + 64'h100, 4'd3, INCR, 8'hFF, 64'd1, 1'b0, '0, -1);
    chk_shape("pre100", 4);
    xact("incr", 1'b0, BASE + 64'h100, 4'd3, INCR, 8'h00, '0, 1'b0, '0, -1);
    chk_shape("incr", 4);
    for (int i = 0; i < 4; i++) chk($sformatf("incr.data%0d", i), got_data[i], 64'(i + 1));
    xact("fixed", 1'b0, BASE + 64'h100, 4'd3, FIXED, 8'h00, '0, 1'b0, '0, -1);
    chk_shape("fixed", 4);
    for (int i = 0; i < 4; i++) chk($sformatf("fixed.data%0d", i), got_data[i], 64'd1);

    xact("b2b0", 1'b0, BASE + 64'h80, 4'd0, INCR, 8'h00, '0, 1'b1, BASE + 64'h100, -1);
    chk_shape("b2b0", 1);
    chk("b2b0.data", got_data[0], 64'hDEAD_BEEF_0123_4567);
    xact("b2b1", 1'b0, BASE + 64'h100, 4'd0, INCR, 8'h00, '0, 1'b1, BASE + 64'h108, -1);
    chk_shape("b2b1", 1);
    chk("b2b1.data", got_data[0], 64'd1);
    xact("b2b2", 1'b0, BASE + 64'h108, 4'd0, INCR, 8'h00, '0, 1'b0, '0, -1);
    chk_shape("b2b2", 1);
    chk("b2b2.data", got_data[0], 64'd2);

    xact("pre0", 1'b1, BASE, 4'd0, INCR, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, '0, -1);
    xact("oobrd", 1'b0, 64'h0, 4'd0, INCR, 8'h00, '0, 1'b0, '0, -1);
    chk_shape("oobrd", 1);
    chk("oobrd.data", got_data[0], 64'd0);
    chk("oobrd.oob", 64'(got_oob[0]), 64'd1);
    xact("oobwr", 1'b1, TOP, 4'd0, INCR, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0, '0, -1);
    chk_shape("oobwr", 1);
    chk("oobwr.oob", 64'(got_oob[0]), 64'd1);
    xact("rd0", 1'b0, BASE, 4'd0, INCR, 8'h00, '0, 1'b0, '0, -1);
    chk("rd0.data", got_data[0], 64'h0123_4567_89AB_CDEF);
    chk("rd0.oob", 64'(got_oob[0]), 64'd0);

    xact("preA", 1'b1, BASE + 64'h200, 4'd7, INCR, 8'hFF, 64'hA0, 1'b0, '0, -1);
    chk_shape("preA", 8);
    xact("rstwr", 1'b1, BASE + 64'h200, 4'd7, INCR, 8'hFF, 64'hB0, 1'b0, '0, 3);
    chk("rstwr.beats", 64'(got_n), 64'd4);
    chk("rstwr.ready", 64'(resp_ready), 64'd0);
    chk("rstwr.last", 64'(resp_last), 64'd0);
    chk("rstwr.data", resp_data, 64'd0);
    chk("rstwr.oob", 64'(oob), 64'd0);
    xact("rdA", 1'b0, BASE + 64'h200, 4'd7, INCR, 8'h00, '0, 1'b0, '0, -1);
    chk_shape("rdA", 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rdA.data%0d", i), got_data[i], (i < 3) ? 64'(8'hB0 + i) : 64'(8'hA0 + i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
